// File: rtl/adventure_game_pkg.sv
// Shared types and constants for the two-player adventure-game turn controller.
package adventure_game_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_STEP,
      S_SETTLE,
      S_CHECK,
      S_OVER
   } state_e;

   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_E = 2'd1;
   localparam logic [1:0] DIR_S = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

endpackage

// File: rtl/adventure_game_turn_timer.sv
// Per-turn inactivity counter; expire flags the last allowed WAIT cycle of a turn.
module adventure_game_turn_timer #(
   parameter int unsigned TURN_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam logic [15:0] LAST = 16'(TURN_TIMEOUT - 1);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)    cnt_d = '0;
      else if (run) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/adventure_game_turn_ctrl.sv
// Two-player turn controller in front of a shared adventure-game engine.
// Optional per-turn forfeit timer is enabled by defining ADV_TURN_TIMEOUT_EN.
module adventure_game_turn_ctrl
   import adventure_game_pkg::*;
#(
   parameter  int unsigned MAX_MOVES    = 16,
   parameter  int unsigned TURN_TIMEOUT = 255,
   localparam int          CNT_W        = $clog2(MAX_MOVES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             new_game,
   input  logic             p0_req,
   input  logic             p1_req,
   input  logic [1:0]       p0_dir,
   input  logic [1:0]       p1_dir,
   output logic             p0_ack,
   output logic             p1_ack,
   output logic             eng_start,
   output logic             eng_step,
   output logic [1:0]       eng_dir,
   input  logic             eng_done,
   input  logic             eng_win,
   output logic             cur_player,
   output logic [CNT_W-1:0] move_cnt,
   output logic             game_over,
   output logic             winner_valid,
   output logic             winner,
   output logic             timeout_pulse
);

   if (MAX_MOVES == 0 || MAX_MOVES > 255 || TURN_TIMEOUT < 2 || TURN_TIMEOUT > 65535)
   begin : g_param_check
      $error("adventure_game_turn_ctrl: parameter out of legal range");
   end

   state_e             state_q, state_d;
   logic               cur_player_q, cur_player_d;
   logic [CNT_W-1:0]   move_cnt_q, move_cnt_d;
   logic [1:0]         eng_dir_q, eng_dir_d;
   logic               p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
   logic               eng_start_q, eng_start_d, eng_step_q, eng_step_d;
   logic               game_over_q, game_over_d;
   logic               winner_valid_q, winner_valid_d, winner_q, winner_d;
   logic               timeout_pulse_q, timeout_pulse_d;
   logic               cur_req, expire;
   logic [1:0]         cur_dir;

   // Only the player whose turn it is can be heard; the other request is masked here.
   assign cur_req = (cur_player_q == P1) ? p1_req : p0_req;
   assign cur_dir = (cur_player_q == P1) ? p1_dir : p0_dir;

`ifdef ADV_TURN_TIMEOUT_EN
   logic timer_clear, timer_run;

   assign timer_run   = (state_q == S_WAIT);
   assign timer_clear = !timer_run || expire;

   adventure_game_turn_timer #(
      .TURN_TIMEOUT (TURN_TIMEOUT)
   ) u_turn_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .run    (timer_run),
      .expire (expire)
   );
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path through the case can infer a latch.
      state_d         = state_q;
      cur_player_d    = cur_player_q;
      move_cnt_d      = move_cnt_q;
      eng_dir_d       = eng_dir_q;
      winner_valid_d  = winner_valid_q;
      winner_d        = winner_q;
      p0_ack_d        = 1'b0;
      p1_ack_d        = 1'b0;
      eng_start_d     = 1'b0;
      eng_step_d      = 1'b0;
      timeout_pulse_d = 1'b0;

      if (new_game) begin
         state_d        = S_START;
         eng_start_d    = 1'b1;
         cur_player_d   = P0;
         move_cnt_d     = '0;
         winner_valid_d = 1'b0;
         winner_d       = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE:   state_d = S_IDLE;
            S_START:  state_d = S_WAIT;
            S_WAIT: begin
               if (cur_req) begin
                  state_d    = S_STEP;
                  eng_dir_d  = cur_dir;
                  eng_step_d = 1'b1;
                  p0_ack_d   = (cur_player_q == P0);
                  p1_ack_d   = (cur_player_q == P1);
               end else if (expire) begin
                  cur_player_d    = ~cur_player_q;
                  timeout_pulse_d = 1'b1;
               end
            end
            S_STEP:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_CHECK;
            S_CHECK: begin
               if (eng_done) begin
                  state_d        = S_OVER;
                  winner_valid_d = 1'b1;
                  winner_d       = eng_win ? cur_player_q : ~cur_player_q;
               end else begin
                  move_cnt_d = move_cnt_q + CNT_W'(1);
                  if (move_cnt_d == CNT_W'(MAX_MOVES)) begin
                     state_d = S_OVER;
                  end else begin
                     state_d      = S_WAIT;
                     cur_player_d = ~cur_player_q;
                  end
               end
            end
            S_OVER:   state_d = S_OVER;
            default:  state_d = S_IDLE;
         endcase
      end

      game_over_d = (state_d == S_OVER);
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         cur_player_q    <= P0;
         move_cnt_q      <= '0;
         eng_dir_q       <= DIR_N;
         p0_ack_q        <= 1'b0;
         p1_ack_q        <= 1'b0;
         eng_start_q     <= 1'b0;
         eng_step_q      <= 1'b0;
         game_over_q     <= 1'b0;
         winner_valid_q  <= 1'b0;
         winner_q        <= 1'b0;
         timeout_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cur_player_q    <= cur_player_d;
         move_cnt_q      <= move_cnt_d;
         eng_dir_q       <= eng_dir_d;
         p0_ack_q        <= p0_ack_d;
         p1_ack_q        <= p1_ack_d;
         eng_start_q     <= eng_start_d;
         eng_step_q      <= eng_step_d;
         game_over_q     <= game_over_d;
         winner_valid_q  <= winner_valid_d;
         winner_q        <= winner_d;
         timeout_pulse_q <= timeout_pulse_d;
      end
   end

   assign p0_ack        = p0_ack_q;
   assign p1_ack        = p1_ack_q;
   assign eng_start     = eng_start_q;
   assign eng_step      = eng_step_q;
   assign eng_dir       = eng_dir_q;
   assign cur_player    = cur_player_q;
   assign move_cnt      = move_cnt_q;
   assign game_over     = game_over_q;
   assign winner_valid  = winner_valid_q;
   assign winner        = winner_q;
   assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_adventure_game_turn_ctrl.sv
// Bench for adventure_game_turn_ctrl: directed turns checked by a turn-level model every cycle.
// Timeout expectations follow ADV_TURN_TIMEOUT_EN when the bench is built with it.
module tb_adventure_game_turn_ctrl;
   import adventure_game_pkg::*;

   localparam int unsigned MAX_MOVES    = 4;
   localparam int unsigned TURN_TIMEOUT = 8;
`ifdef ADV_TURN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk, reset, new_game;
   logic       p0_req, p1_req;
   logic [1:0] p0_dir, p1_dir;
   logic       p0_ack, p1_ack, eng_start, eng_step;
   logic [1:0] eng_dir;
   logic       eng_done, eng_win;
   logic       cur_player, game_over, winner_valid, winner, timeout_pulse;
   logic [2:0] move_cnt;

   int n_checks = 0;
   int n_errors = 0;

   adventure_game_turn_ctrl #(
      .MAX_MOVES    (MAX_MOVES),
      .TURN_TIMEOUT (TURN_TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .new_game      (new_game),
      .p0_req        (p0_req),
      .p1_req        (p1_req),
      .p0_dir        (p0_dir),
      .p1_dir        (p1_dir),
      .p0_ack        (p0_ack),
      .p1_ack        (p1_ack),
      .eng_start     (eng_start),
      .eng_step      (eng_step),
      .eng_dir       (eng_dir),
      .eng_done      (eng_done),
      .eng_win       (eng_win),
      .cur_player    (cur_player),
      .move_cnt      (move_cnt),
      .game_over     (game_over),
      .winner_valid  (winner_valid),
      .winner        (winner),
      .timeout_pulse (timeout_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Turn-level model: a game is live or over; a granted move ages 0..2 cycles and is
   // scored on its third cycle; age -1 means the current player is being waited on.
   bit         m_live, e_over, e_cur, e_wv, e_win;
   bit         e_ack0, e_ack1, e_step, e_start, e_to;
   int         m_age, m_idle, e_cnt;
   logic [1:0] e_dir;

   initial begin
      m_live = 0; e_over = 0; e_cur = 0; e_wv = 0; e_win = 0; e_cnt = 0; e_dir = DIR_N;
      e_ack0 = 0; e_ack1 = 0; e_step = 0; e_start = 0; e_to = 0; m_age = 0; m_idle = 0;
      forever begin
         @(posedge clk);
         e_ack0 = 0; e_ack1 = 0; e_step = 0; e_start = 0; e_to = 0;
         if (!reset) begin
            m_live = 0; e_over = 0; e_cur = 0; e_wv = 0; e_win = 0; e_cnt = 0;
            e_dir = DIR_N; m_age = 0; m_idle = 0;
         end else if (new_game) begin
            m_live = 1; e_over = 0; e_cur = 0; e_wv = 0; e_win = 0; e_cnt = 0;
            e_start = 1; m_age = -2;
         end else if (m_live && !e_over) begin
            if (m_age == -2) begin
               m_age = -1; m_idle = 0;
            end else if (m_age == -1) begin
               if (e_cur ? p1_req : p0_req) begin
                  e_dir  = e_cur ? p1_dir : p0_dir;
                  e_ack0 = !e_cur; e_ack1 = e_cur; e_step = 1; m_age = 0;
               end else if (TO_EN && m_idle == int'(TURN_TIMEOUT) - 1) begin
                  e_cur = !e_cur; e_to = 1; m_idle = 0;
               end else begin
                  m_idle++;
               end
            end else if (m_age < 2) begin
               m_age++;
            end else if (eng_done) begin
               e_over = 1; e_wv = 1; e_win = eng_win ? e_cur : !e_cur;
            end else begin
               e_cnt++;
               if (e_cnt == int'(MAX_MOVES)) e_over = 1;
               else begin e_cur = !e_cur; m_age = -1; m_idle = 0; end
            end
         end
         #2;
         check("p0_ack", p0_ack, e_ack0);
         check("p1_ack", p1_ack, e_ack1);
         check("eng_step", eng_step, e_step);
         check("eng_start", eng_start, e_start);
         check("eng_dir", eng_dir, e_dir);
         check("cur_player", cur_player, e_cur);
         check("move_cnt", move_cnt, e_cnt);
         check("game_over", game_over, e_over);
         check("winner_valid", winner_valid, e_wv);
         check("winner", winner, e_win);
         check("timeout_pulse", timeout_pulse, e_to);
      end
   end

   initial begin
      reset = 0; new_game = 0; p0_req = 0; p1_req = 0; p0_dir = DIR_N; p1_dir = DIR_N;
      eng_done = 0; eng_win = 0;
      cyc(3);
      check("lit_rst_game_over", game_over, 0);
      check("lit_rst_eng_dir", eng_dir, DIR_N);
      check("lit_rst_move_cnt", move_cnt, 0);
      reset = 1;
      cyc(1);

      // Game 1: p0 East, p1 South (p1 holds its request through p0's turn), then p1 wins.
      new_game = 1; cyc(1);
      new_game = 0;
      check("lit_start_pulse", eng_start, 1);
      cyc(1);
      p0_req = 1; p0_dir = DIR_E; p1_req = 1; p1_dir = DIR_S;
      cyc(1);
      check("lit_p0_ack", p0_ack, 1);
      check("lit_p1_masked", p1_ack, 0);
      check("lit_dir_e", eng_dir, DIR_E);
      p0_req = 0;
      cyc(3);
      check("lit_turn_p1", cur_player, 1);
      check("lit_cnt1", move_cnt, 1);
      cyc(1);
      check("lit_p1_ack", p1_ack, 1);
      check("lit_dir_s", eng_dir, DIR_S);
      p1_req = 0;
      cyc(3);
      check("lit_cnt2", move_cnt, 2);
      check("lit_turn_p0", cur_player, 0);
      p0_req = 1; p0_dir = DIR_W; cyc(1);
      p0_req = 0; cyc(3);
      p1_req = 1; p1_dir = DIR_N; cyc(1);
      p1_req = 0; eng_done = 1; eng_win = 1;
      cyc(3);
      check("lit_win_over", game_over, 1);
      check("lit_win_valid", winner_valid, 1);
      check("lit_winner_p1", winner, 1);
      check("lit_win_cnt", move_cnt, 3);
      eng_done = 0; eng_win = 0;
      cyc(3);
      check("lit_over_hold", winner, 1);

      // Game 2: four moves with no engine end -> draw at MAX_MOVES.
      new_game = 1; cyc(1);
      new_game = 0;
      check("lit_new_cnt", move_cnt, 0);
      check("lit_new_wv", winner_valid, 0);
      check("lit_new_over", game_over, 0);
      cyc(1);
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) begin p0_req = 1; p0_dir = 2'(k); end
         else            begin p1_req = 1; p1_dir = 2'(k); end
         cyc(1);
         p0_req = 0; p1_req = 0;
         cyc(3);
      end
      check("lit_draw_over", game_over, 1);
      check("lit_draw_wv", winner_valid, 0);
      check("lit_draw_cnt", move_cnt, 4);
      check("lit_draw_dir", eng_dir, DIR_W);

      // Game 3: new_game during SETTLE abandons the move.
      new_game = 1; cyc(1);
      new_game = 0; cyc(1);
      p0_req = 1; p0_dir = DIR_S; cyc(1);
      p0_req = 0; cyc(1);
      new_game = 1; cyc(1);
      new_game = 0;
      check("lit_abandon_start", eng_start, 1);
      check("lit_abandon_ack", p0_ack, 0);
      check("lit_abandon_cnt", move_cnt, 0);
      cyc(1);

      // Reset while STEP is presented.
      p0_req = 1; p0_dir = DIR_E; cyc(1);
      check("lit_step_before_rst", eng_step, 1);
      reset = 0; p0_req = 0;
      cyc(1);
      check("lit_rst_step", eng_step, 0);
      check("lit_rst_ack", p0_ack, 0);
      check("lit_rst_dir", eng_dir, DIR_N);
      reset = 1;
      cyc(2);
      check("lit_idle_start", eng_start, 0);
      check("lit_idle_over", game_over, 0);

      // Game 4: p0 idles for TURN_TIMEOUT WAIT cycles.
      new_game = 1; cyc(1);
      new_game = 0; cyc(1);
      cyc(TURN_TIMEOUT - 1);
      check("lit_no_early_timeout", timeout_pulse, 0);
      cyc(1);
      check("lit_timeout_pulse", timeout_pulse, TO_EN);
      check("lit_timeout_turn", cur_player, TO_EN);
      check("lit_timeout_cnt", move_cnt, 0);
      cyc(1);
      p0_req = 1; p1_req = 1; cyc(1);
      check("lit_after_timeout_step", eng_step, 1);
      p0_req = 0; p1_req = 0;
      cyc(4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/adventure_game_turn_ctrl.md
# adventure_game_turn_ctrl

Two-player turn controller that shares one adventure-game engine (room FSM plus sword FSM) between two requesters. It starts a game, grants moves alternately, presents exactly one direction step per granted move, counts moves, and resolves win, loss or draw from the engine's end-of-game flags. It sits between the player input logic and the engine's start/direction inputs.

## Interface
Parameters:
- MAX_MOVES, 16: total accepted moves before a draw is declared; legal range 1..255.
- TURN_TIMEOUT, 255: WAIT cycles before the current player forfeits the turn; legal range 2..65535.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- new_game  in  1  level-sampled; a 1 in any state starts a fresh game.
- p0_req / p1_req  in  1  move request from player 0 / player 1.
- p0_dir / p1_dir  in  2  direction code: 0=N, 1=E, 2=S, 3=W.
- p0_ack / p1_ack  out  1  one-cycle grant for the request.
- eng_start  out  1  one-cycle engine start pulse.
- eng_step  out  1  one-cycle pulse; engine consumes eng_dir in this cycle.
- eng_dir  out  2  registered direction; holds its value between steps.
- eng_done  in  1  engine reports that the game has ended.
- eng_win  in  1  qualifies eng_done: 1=win, 0=loss.
- cur_player  out  1  player whose turn it is.
- move_cnt  out  $clog2(MAX_MOVES+1)  count of accepted moves.
- game_over  out  1  high while in OVER.
- winner_valid  out  1  1 means winner is meaningful; 0 with game_over means draw.
- winner  out  1  winning player index.
- timeout_pulse  out  1  one-cycle pulse on a forfeited turn.

## Operation
- States: IDLE, START, WAIT, STEP, SETTLE, CHECK, OVER.
- IDLE: all outputs 0. new_game=1 moves the FSM to START.
- START: eng_start=1. Clear cur_player, move_cnt, winner_valid, winner and the timeout counter. Next state is WAIT.
- WAIT: sample only the request of cur_player; the other player's request is ignored and not acked. When the request is 1, capture the matching direction into eng_dir and go to STEP.
- STEP: the ack for cur_player =1 and eng_step=1. Next state is SETTLE.
- SETTLE: one idle cycle so the engine state propagates. Next state is CHECK.
- CHECK: if eng_done=1, go to OVER with winner_valid=1 and winner = eng_win ? cur_player : ~cur_player. Otherwise increment move_cnt. If the new count equals MAX_MOVES, go to OVER with winner_valid=0 (draw). Otherwise toggle cur_player and go to WAIT.
- OVER: game_over=1; winner and move_cnt hold. Stay until new_game=1.
- new_game=1 has priority over every other transition in every state and goes to START. An in-flight move is abandoned and no further ack or step is issued for it.
- Reset at any time forces IDLE and zeroes every register and output.
- move_cnt never wraps; it saturates because the transition to OVER happens at MAX_MOVES.

## Timing
- Reset value of every output is 0. eng_dir resets to 0 (N).
- Request 1 in WAIT at cycle n: ack and eng_step at n+1, SETTLE at n+2, CHECK at n+3, next WAIT at n+4.
- ack, eng_step, eng_start and timeout_pulse are one cycle wide and come straight from registered state; there are no combinational paths from inputs to outputs.
- eng_done and eng_win are sampled only in CHECK.
- A request held high across turns is not double-counted, because it is sampled only in WAIT.

## Configuration
- ADV_TURN_TIMEOUT_EN defined: the timeout counter increments every WAIT cycle and clears on leaving WAIT. When it reaches TURN_TIMEOUT-1 with no request, the next cycle gives timeout_pulse=1, toggles cur_player, clears the counter and stays in WAIT. move_cnt is unchanged. If the request and the timeout land in the same cycle, the request wins.
- ADV_TURN_TIMEOUT_EN undefined: there is no counter, timeout_pulse is tied to 0, and WAIT waits indefinitely.

## Structure
- Shared package adventure_game_pkg holds:
  - the state enum;
  - the direction constants DIR_N, DIR_E, DIR_S, DIR_W;
  - the player index constants P0 and P1.
- Sub-module adventure_game_turn_timer holds the timeout counter, with inputs clear and run and output expire. It is instantiated only under ADV_TURN_TIMEOUT_EN.

## Test plan
- Reset low mid-STEP -> all outputs 0 next edge; IDLE after release.
- new_game, p0 dir=1, then p1 dir=2, with eng_done=0 -> p0_ack/eng_dir=1, then p1_ack/eng_dir=2; move_cnt=2; cur_player=0.
- p1_req held high during p0's turn -> no p1_ack until cur_player=1.
- eng_done=1, eng_win=1 at CHECK of p1's move -> game_over=1, winner_valid=1, winner=1.
- MAX_MOVES=4, eng_done always 0 -> OVER after 4th move, winner_valid=0, move_cnt=4.
- With ADV_TURN_TIMEOUT_EN and TURN_TIMEOUT=8: p0 idle 8 cycles -> timeout_pulse, cur_player=1, move_cnt=0. new_game in SETTLE -> eng_start next cycle, no ack for the abandoned move.
